alu_seq: RTL
============

# alu_seq

Parametrised, registered successor to the team's 8-bit combinational ALU. Keeps the existing 3-bit opcode map for add/sub/invert/and/or/xor and adds a logical right shift and an optional iterative multiplier. Inputs are accepted with a start/busy/done handshake, results are registered, and Z/C/N/V status flags are produced. It sits between the datapath register file and the writeback mux in micro-tile CPU designs.

## Interface
Parameters:
- W, 8, operand/result width; power of two, W ≥ 4
Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled on the rising edge when busy=0
- op  in  3  opcode, captured with start
- X  in  W  operand A, captured with start
- Y  in  W  operand B, captured with start
- F  out  W  registered result
- flags  out  4  {Z, C, N, V}, registered, updated with F
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse; F/flags updated on that same edge

## Operation
- Opcodes: 000 ADD X+Y; 001 SUB X−Y; 010 MUL, low W bits of X*Y; 011 SHR, X >> Y[log2(W)-1:0] logical; 100 NOT ~X; 101 AND; 110 OR; 111 XOR.
- All arithmetic is mod 2^W and unsigned, except V.
- Z = (F==0). N = F[W-1].
- C: ADD = carry out of bit W-1. SUB = borrow, i.e. 1 when X<Y unsigned. MUL = 1 when product bits [2W-1:W] ≠ 0. SHR = last bit shifted out (X[s-1] for shift s>0), 0 when s=0. Logic ops = 0.
- V: ADD/SUB = signed two's-complement overflow. All other ops = 0.
- States: IDLE, MUL.
  - IDLE with start and op≠010: compute and register F/flags; pulse done; stay in IDLE.
  - IDLE with start and op=010: load multiplicand, multiplier and a 2W-bit accumulator; busy=1; go to MUL.
  - MUL: one shift-add step per cycle for W cycles. On the Wth step: write F/flags, pulse done, busy=0, return to IDLE.
- start while busy=1 is ignored; operands are not recaptured.
- Inputs may change freely after the capture edge.
- Asynchronous reset mid-operation aborts the multiply and returns to IDLE. F=0, flags=0, busy=0, done=0, accumulator cleared.

## Timing
- Reset values: F=0, flags=4'b0000, busy=0, done=0, state IDLE.
- Single-cycle ops: start sampled at edge k. F/flags valid and done=1 after edge k. done drops after edge k+1 unless a new start is sampled at k+1.
  - Back-to-back starts give one result per cycle, with done held high.
- MUL: start sampled at edge k, and busy=1 after edge k. The result is written, done=1 and busy=0 after edge k+W. Latency is W cycles.
  - A new start is accepted at edge k+W+1 at the earliest, because busy is still 1 at edge k+W.
- F/flags hold their values between done pulses.

## Configuration
- ALU_MUL_EN defined: multiplier present, with the MUL state and behaviour above.
- ALU_MUL_EN undefined: the MUL state and accumulator are removed. Op 010 completes in a single cycle like the other ops, with F=0, flags={1,0,0,0} and busy never asserted.

## Test plan
- Reset: assert rst_n=0 mid-stream -> F=0, flags=0, busy=0, done=0 immediately. Release, then start ADD 3+4 -> F=7, flags=0000, done for 1 cycle.
- ADD/SUB boundaries (W=8):
  - 0xFF+0x01 -> F=0x00, Z=1, C=1, V=0.
  - 0x7F+0x01 -> F=0x80, N=1, V=1.
  - 0x00−0x01 -> F=0xFF, C=1, N=1.
- Logic/shift:
  - NOT 0x0F -> 0xF0.
  - SHR 0x81 by 1 -> F=0x40, C=1.
  - SHR by 0 -> F=X, C=0.
  - XOR 0xAA^0xAA -> Z=1.
- MUL (ALU_MUL_EN): 13*11 -> done exactly 8 cycles after the start edge, F=0x8F, C=0. 0x10*0x10 -> F=0x00, Z=1, C=1. busy=1 throughout.
- Handshake:
  - A start pulse during a MUL is ignored, with exactly one done pulse.
  - Back-to-back single-cycle starts (ADD, AND, OR) -> three consecutive correct F values.
  - Reset asserted at cycle 3 of a MUL -> no done pulse; outputs return to reset values.
- Build without ALU_MUL_EN: op 010 -> done after 1 cycle, F=0, Z=1, busy never 1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake, Z/C/N/V flags and logical right shift.
// Define ALU_MUL_EN to include the iterative shift-add multiplier (op 010); otherwise op 010 returns 0.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    output logic [W-1:0] F,
    output logic [3:0]   flags,
    output logic         busy,
    output logic         done
);

    localparam int SW = $clog2(W);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    logic [W:0]    add_full;
    logic [W:0]    sub_full;
    logic [SW-1:0] sh_amt;
    logic [W-1:0]  sc_res;
    logic          sc_c;
    logic          sc_v;
    logic [3:0]    sc_flags;

    assign add_full = {1'b0, X} + {1'b0, Y};
    assign sub_full = {1'b0, X} - {1'b0, Y};
    assign sh_amt   = Y[SW-1:0];

    // Result and flags for every op that completes in one cycle; op 010 yields 0 here.
    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res = add_full[W-1:0];
                sc_c   = add_full[W];
                sc_v   = (X[W-1] == Y[W-1]) && (add_full[W-1] != X[W-1]);
            end
            OP_SUB: begin
                sc_res = sub_full[W-1:0];
                sc_c   = sub_full[W];
                sc_v   = (X[W-1] != Y[W-1]) && (sub_full[W-1] != X[W-1]);
            end
            OP_MUL: begin
                sc_res = '0;
            end
            OP_SHR: begin
                sc_res = X >> sh_amt;
                // Carry is the last bit shifted out, X[s-1]; the index wraps harmlessly when s=0.
                sc_c   = (sh_amt != '0) ? X[sh_amt - SW'(1)] : 1'b0;
            end
            OP_NOT: sc_res = ~X;
            OP_AND: sc_res = X & Y;
            OP_OR:  sc_res = X | Y;
            OP_XOR: sc_res = X ^ Y;
            default: sc_res = '0;
        endcase
    end

    assign sc_flags = {(sc_res == '0), sc_c, sc_res[W-1], sc_v};

`ifdef ALU_MUL_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;
    localparam logic [SW-1:0] LAST_STEP = SW'(W - 1);

    logic [0:0]     state_reg;
    logic [2*W-1:0] mcand_reg;
    logic [2*W-1:0] acc_reg;
    logic [2*W-1:0] acc_next;
    logic [W-1:0]   mplier_reg;
    logic [SW-1:0]  count_reg;

    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            F          <= '0;
            flags      <= 4'b0000;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mcand_reg  <= {{W{1'b0}}, X};
                            mplier_reg <= Y;
                            acc_reg    <= '0;
                            count_reg  <= '0;
                            state_reg  <= ST_MUL;
                        end else begin
                            F     <= sc_res;
                            flags <= sc_flags;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + SW'(1);
                    // Final partial product is folded in combinationally so the result lands on step W.
                    if (count_reg == LAST_STEP) begin
                        F         <= acc_next[W-1:0];
                        flags     <= {(acc_next[W-1:0] == '0), (acc_next[2*W-1:W] != '0),
                                      acc_next[W-1], 1'b0};
                        done      <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == ST_MUL);
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F     <= '0;
            flags <= 4'b0000;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                F     <= sc_res;
                flags <= sc_flags;
                done  <= 1'b1;
            end
        end
    end

    assign busy = 1'b0;
`endif

endmodule
